// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache that fronts the memory controller's fetch port.
// Define ICACHE_STAT_EN to build the saturating hit/miss counters; otherwise stat_hit/stat_miss read 0.
module icache_dm #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_flush,
    output logic              if_ready,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    output logic              mc_rn,
    output logic [31:0]       mc_addr,
    input  logic              mc_ready,
    input  logic [31:0]       mc_value,
    output logic [31:0]       stat_hit,
    output logic [31:0]       stat_miss
);
    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                cancel_q, cancel_d;
    logic                if_valid_q, if_valid_d;
    logic [31:0]         if_inst_q, if_inst_d;
    logic                mc_rn_q, mc_rn_d;
    logic [31:0]         mc_addr_q, mc_addr_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [INDEX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]    req_tag, fill_tag;
    logic                hit, fill_en, hit_evt, miss_evt;
    logic [ADDR_W-1:0]   word_addr;
    logic [1:0]          unused_pc_lsb;

    assign req_idx       = if_pc[INDEX_W+1:2];
    assign req_tag       = if_pc[ADDR_W-1:INDEX_W+2];
    assign fill_idx      = pc_q[INDEX_W+1:2];
    assign fill_tag      = pc_q[ADDR_W-1:INDEX_W+2];
    assign hit           = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign word_addr     = {if_pc[ADDR_W-1:2], 2'b00};
    assign unused_pc_lsb = if_pc[1:0] ^ pc_q[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cancel_d   = cancel_q;
        if_valid_d = 1'b0;
        if_inst_d  = if_inst_q;
        mc_rn_d    = mc_rn_q;
        mc_addr_d  = mc_addr_q;
        fill_en    = 1'b0;
        hit_evt    = 1'b0;
        miss_evt   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cancel_d = 1'b0;
                if (if_req && !if_flush) begin
                    if (hit) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = data_q[req_idx];
                        hit_evt    = 1'b1;
                    end else begin
                        pc_d      = if_pc;
                        mc_rn_d   = 1'b1;
                        mc_addr_d = 32'(word_addr);
                        miss_evt  = 1'b1;
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (if_flush) cancel_d = 1'b1;
                if (!mc_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (if_flush) cancel_d = 1'b1;
                if (mc_ready) begin
                    // The fill always completes; a redirect only suppresses the return to fetch.
                    fill_en = 1'b1;
                    mc_rn_d = 1'b0;
                    state_d = S_IDLE;
                    if (!(cancel_q || if_flush)) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = mc_value;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cancel_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_inst_q  <= 32'd0;
            mc_rn_q    <= 1'b0;
            mc_addr_q  <= 32'd0;
            valid_q    <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cancel_q   <= cancel_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            mc_rn_q    <= mc_rn_d;
            mc_addr_q  <= mc_addr_d;
            if (fill_en) valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && !rst) begin
            pc_q <= pc_d;
            if (fill_en) begin
                tag_q[fill_idx]  <= fill_tag;
                data_q[fill_idx] <= mc_value;
            end
        end
    end

    assign if_ready = (state_q == S_IDLE);
    assign if_valid = if_valid_q;
    assign if_inst  = if_inst_q;
    assign mc_rn    = mc_rn_q;
    assign mc_addr  = mc_addr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] stat_hit_q, stat_miss_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hit_q  <= 32'd0;
            stat_miss_q <= 32'd0;
        end else if (rdy) begin
            if (hit_evt)  stat_hit_q  <= sat_inc(stat_hit_q);
            if (miss_evt) stat_miss_q <= sat_inc(stat_miss_q);
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;
`else
    logic unused_stat_evt;
    assign unused_stat_evt = hit_evt ^ miss_evt;
    assign stat_hit        = 32'd0;
    assign stat_miss       = 32'd0;
`endif
endmodule
